// File: rtl/hazard_sched.sv
// hazard_sched: pipeline hazard unit with data-memory wait scheduler.
// Resolves RAW hazards by forwarding/stalling and holds the whole pipeline
// while a variable-latency data memory access is outstanding.
// Build option: define HAZARD_FWD_EN to enable operand forwarding, load-use
// and branch stall detection; otherwise every D-stage RAW dependency on E or M
// stalls and all forward selects stay at the register file.
module hazard_sched #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] writereg_e,
  input  logic [4:0] writereg_m,
  input  logic [4:0] writereg_w,
  input  logic       regwrite_e,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  input  logic       memtoreg_e,
  input  logic       memtoreg_m,
  input  logic       branch_d,
  input  logic       pcsrc_d,
  input  logic       memaccess_m,
  input  logic       dmem_ack,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_w,
  output logic [1:0] forwarda_e,
  output logic [1:0] forwardb_e,
  output logic       forwarda_d,
  output logic       forwardb_d,
  output logic       dmem_req,
  output logic       mem_busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Counter value seen during the last permitted WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_err_q, timeout_err_d;
  logic       busy_raw;

  // A producer matches a consumer only for a nonzero register it really writes.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic we);
    return we && (src != 5'd0) && (src == dst);
  endfunction

  logic e_match_rs_d, e_match_rt_d;
  logic m_match_rs_d, m_match_rt_d;
  logic m_match_rs_e, m_match_rt_e;
  logic w_match_rs_e, w_match_rt_e;

  assign e_match_rs_d = reg_match(rs_d, writereg_e, regwrite_e);
  assign e_match_rt_d = reg_match(rt_d, writereg_e, regwrite_e);
  assign m_match_rs_d = reg_match(rs_d, writereg_m, regwrite_m);
  assign m_match_rt_d = reg_match(rt_d, writereg_m, regwrite_m);
  assign m_match_rs_e = reg_match(rs_e, writereg_m, regwrite_m);
  assign m_match_rt_e = reg_match(rt_e, writereg_m, regwrite_m);
  assign w_match_rs_e = reg_match(rs_e, writereg_w, regwrite_w);
  assign w_match_rt_e = reg_match(rt_e, writereg_w, regwrite_w);

  // Raw hazard decisions before reset/memory gating.
  logic       hazard_stall;
  logic [1:0] fwd_a_e_raw, fwd_b_e_raw;
  logic       fwd_a_d_raw, fwd_b_d_raw;

`ifdef HAZARD_FWD_EN
  logic lwstall, brstall;

  // E-stage operand select: the younger M result wins over W.
  always_comb begin
    fwd_a_e_raw = 2'b00;
    fwd_b_e_raw = 2'b00;
    if (m_match_rs_e)      fwd_a_e_raw = 2'b10;
    else if (w_match_rs_e) fwd_a_e_raw = 2'b01;
    if (m_match_rt_e)      fwd_b_e_raw = 2'b10;
    else if (w_match_rt_e) fwd_b_e_raw = 2'b01;
  end

  assign fwd_a_d_raw = m_match_rs_d;
  assign fwd_b_d_raw = m_match_rt_d;

  // A load in E cannot forward its data in time to the instruction in D.
  assign lwstall = memtoreg_e && (rt_e != 5'd0) && ((rt_e == rs_d) || (rt_e == rt_d));

  // The branch compares in D, so it waits for an E producer or an M load.
  assign brstall = branch_d &&
                   (e_match_rs_d || e_match_rt_d ||
                    (memtoreg_m && (m_match_rs_d || m_match_rt_d)));

  assign hazard_stall = lwstall || brstall;
`else
  // Without forwarding any E or M producer of a D source must drain first;
  // W producers are safe because the register file writes early in the cycle.
  assign fwd_a_e_raw  = 2'b00;
  assign fwd_b_e_raw  = 2'b00;
  assign fwd_a_d_raw  = 1'b0;
  assign fwd_b_d_raw  = 1'b0;
  assign hazard_stall = e_match_rs_d || e_match_rt_d || m_match_rs_d || m_match_rt_d;

  // Inputs only meaningful when forwarding is built in.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{memtoreg_e, memtoreg_m, branch_d,
                               m_match_rs_e, m_match_rt_e, w_match_rs_e, w_match_rt_e};
`endif

  // Memory FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Memory FSM next state; acks outside WAIT are ignored, ack beats timeout.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    busy_raw      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memaccess_m) begin
          busy_raw = 1'b1;
          state_d  = ST_WAIT;
          cnt_d    = 8'd0;
        end
      end
      ST_WAIT: begin
        busy_raw = 1'b1;
        if (dmem_ack) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TIMEOUT_LAST) begin
            state_d       = ST_DONE;
            timeout_err_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // One cycle for the pipeline to advance past the finished access.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pipeline controls: memory hold overrides hazard stalls and flushes.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    forwarda_e = 2'b00;
    forwardb_e = 2'b00;
    forwarda_d = 1'b0;
    forwardb_d = 1'b0;
    dmem_req   = 1'b0;
    mem_busy   = 1'b0;
    if (!reset) begin
      forwarda_e = fwd_a_e_raw;
      forwardb_e = fwd_b_e_raw;
      forwarda_d = fwd_a_d_raw;
      forwardb_d = fwd_b_d_raw;
      dmem_req   = busy_raw;
      mem_busy   = busy_raw;
      if (busy_raw) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        stall_f = hazard_stall;
        stall_d = hazard_stall;
        flush_e = hazard_stall;
        flush_d = pcsrc_d && !hazard_stall;
      end
    end
  end

  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed plus random stimulus against a cycle-level
// reference model; a monitor pops expected outputs from a scoreboard queue.
module tb_hazard_sched;

  localparam int unsigned TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
  logic       branch_d, pcsrc_d, memaccess_m, dmem_ack;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] forwarda_e, forwardb_e;
  logic       forwarda_d, forwardb_d, dmem_req, mem_busy, timeout_err;

  hazard_sched #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .branch_d(branch_d), .pcsrc_d(pcsrc_d),
    .memaccess_m(memaccess_m), .dmem_ack(dmem_ack),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .forwarda_e(forwarda_e), .forwardb_e(forwardb_e),
    .forwarda_d(forwarda_d), .forwardb_d(forwardb_d),
    .dmem_req(dmem_req), .mem_busy(mem_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0] fa_e, fb_e;
    logic       fa_d, fb_d, req, busy, terr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference memory model: 0 = idle, 1 = waiting, 2 = finishing.
  int   m_phase  = 0;
  int   m_waited = 0;
  bit   m_terr   = 0;

  function automatic bit hits(input logic [4:0] src, input logic [4:0] dst, input logic we);
    return (we === 1'b1) && (src != 0) && (src == dst);
  endfunction

  task automatic clear_inputs();
    reset = 0; rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    writereg_e = 0; writereg_m = 0; writereg_w = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    memtoreg_e = 0; memtoreg_m = 0; branch_d = 0; pcsrc_d = 0;
    memaccess_m = 0; dmem_ack = 0;
  endtask

  // Compute this cycle's expected outputs, queue them, then advance the model.
  task automatic step();
    exp_t e;
    bit   hz, busy;
    e.id = txn; txn++;
    e.stall_f = 0; e.stall_d = 0; e.stall_e = 0; e.stall_m = 0;
    e.flush_d = 0; e.flush_e = 0; e.flush_w = 0;
    e.fa_e = 0; e.fb_e = 0; e.fa_d = 0; e.fb_d = 0;
    busy = (m_phase == 1) || (m_phase == 0 && memaccess_m);
`ifdef HAZARD_FWD_EN
    if (hits(rs_e, writereg_m, regwrite_m))      e.fa_e = 2;
    else if (hits(rs_e, writereg_w, regwrite_w)) e.fa_e = 1;
    if (hits(rt_e, writereg_m, regwrite_m))      e.fb_e = 2;
    else if (hits(rt_e, writereg_w, regwrite_w)) e.fb_e = 1;
    e.fa_d = hits(rs_d, writereg_m, regwrite_m);
    e.fb_d = hits(rt_d, writereg_m, regwrite_m);
    hz = (memtoreg_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d)) ||
         (branch_d && (hits(rs_d, writereg_e, regwrite_e) || hits(rt_d, writereg_e, regwrite_e) ||
                       (memtoreg_m && (hits(rs_d, writereg_m, regwrite_m) ||
                                       hits(rt_d, writereg_m, regwrite_m)))));
`else
    hz = hits(rs_d, writereg_e, regwrite_e) || hits(rt_d, writereg_e, regwrite_e) ||
         hits(rs_d, writereg_m, regwrite_m) || hits(rt_d, writereg_m, regwrite_m);
`endif
    if (busy) begin
      e.stall_f = 1; e.stall_d = 1; e.stall_e = 1; e.stall_m = 1; e.flush_w = 1;
    end else begin
      e.stall_f = hz; e.stall_d = hz; e.flush_e = hz; e.flush_d = pcsrc_d && !hz;
    end
    e.req = busy; e.busy = busy;
    if (reset) begin
      e.stall_f = 0; e.stall_d = 0; e.stall_e = 0; e.stall_m = 0;
      e.flush_d = 0; e.flush_e = 0; e.flush_w = 0;
      e.fa_e = 0; e.fb_e = 0; e.fa_d = 0; e.fb_d = 0; e.req = 0; e.busy = 0;
    end
    e.terr = m_terr;
    exp_q.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_phase = 0; m_waited = 0; m_terr = 0;
    end else if (m_phase == 0) begin
      if (memaccess_m) begin m_phase = 1; m_waited = 0; end
    end else if (m_phase == 1) begin
      m_waited++;
      if (dmem_ack) m_phase = 2;
      else if (m_waited == TMO) begin m_phase = 2; m_terr = 1; end
    end else begin
      m_phase = 0;
    end
    #1;
  endtask

  task automatic chk(input string nm, input int id, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn %0d: got %b expected %b", nm, id, act, exp);
    end
  endtask

  // Monitor: outputs are settled by the falling edge of each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_f", e.id, {1'b0, stall_f}, {1'b0, e.stall_f});
        chk("stall_d", e.id, {1'b0, stall_d}, {1'b0, e.stall_d});
        chk("stall_e", e.id, {1'b0, stall_e}, {1'b0, e.stall_e});
        chk("stall_m", e.id, {1'b0, stall_m}, {1'b0, e.stall_m});
        chk("flush_d", e.id, {1'b0, flush_d}, {1'b0, e.flush_d});
        chk("flush_e", e.id, {1'b0, flush_e}, {1'b0, e.flush_e});
        chk("flush_w", e.id, {1'b0, flush_w}, {1'b0, e.flush_w});
        chk("forwarda_e", e.id, forwarda_e, e.fa_e);
        chk("forwardb_e", e.id, forwardb_e, e.fb_e);
        chk("forwarda_d", e.id, {1'b0, forwarda_d}, {1'b0, e.fa_d});
        chk("forwardb_d", e.id, {1'b0, forwardb_d}, {1'b0, e.fb_d});
        chk("dmem_req", e.id, {1'b0, dmem_req}, {1'b0, e.req});
        chk("mem_busy", e.id, {1'b0, mem_busy}, {1'b0, e.busy});
        chk("timeout_err", e.id, {1'b0, timeout_err}, {1'b0, e.terr});
        $display("txn %0d: stall=%b%b%b%b flush=%b%b%b fwd=%b/%b/%b%b req=%b busy=%b terr=%b",
                 e.id, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                 forwarda_e, forwardb_e, forwarda_d, forwardb_d, dmem_req, mem_busy, timeout_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    // Reset state, with a pending access that must not be requested.
    memaccess_m = 1; step(); step();
    clear_inputs();

    // Forwarding priority and register zero.
    regwrite_m = 1; writereg_m = 5; regwrite_w = 1; writereg_w = 5; rs_e = 5; step();
    regwrite_m = 0; step();
    regwrite_m = 1; writereg_m = 0; writereg_w = 0; step();
    clear_inputs();

    // Load-use hazard and rt_e = 0.
    memtoreg_e = 1; rt_e = 8; rs_d = 8; step();
    rt_e = 0; step();
    clear_inputs();

    // Taken branch, then taken branch blocked by an E producer.
    pcsrc_d = 1; step();
    branch_d = 1; regwrite_e = 1; writereg_e = 3; rs_d = 3; step();
    clear_inputs();

    // Memory access acknowledged on the third WAIT cycle, ack in IDLE ignored.
    dmem_ack = 1; step();
    dmem_ack = 0; memaccess_m = 1; step();
    memaccess_m = 0; step(); step();
    dmem_ack = 1; step();
    dmem_ack = 1; memaccess_m = 1; pcsrc_d = 1; step();
    clear_inputs(); step();

    // Timeout after TMO WAIT cycles, sticky flag, then reset mid-WAIT.
    memaccess_m = 1; step();
    memaccess_m = 0;
    for (int i = 0; i < TMO; i++) step();
    step(); step(); step();
    memaccess_m = 1; step();
    memaccess_m = 0; step();
    reset = 1; step();
    reset = 0; step(); step();
    clear_inputs();

    // D-stage dependency on an M producer.
    regwrite_m = 1; writereg_m = 4; rt_d = 4; step();
    clear_inputs();

    // Randomized traffic over a small register set to provoke matches.
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      rs_d        = 5'($urandom_range(0, 3));
      rt_d        = 5'($urandom_range(0, 3));
      rs_e        = 5'($urandom_range(0, 3));
      rt_e        = 5'($urandom_range(0, 3));
      writereg_e  = 5'($urandom_range(0, 3));
      writereg_m  = 5'($urandom_range(0, 3));
      writereg_w  = 5'($urandom_range(0, 3));
      regwrite_e  = 1'($urandom_range(0, 1));
      regwrite_m  = 1'($urandom_range(0, 1));
      regwrite_w  = 1'($urandom_range(0, 1));
      memtoreg_e  = 1'($urandom_range(0, 1));
      memtoreg_m  = 1'($urandom_range(0, 1));
      branch_d    = 1'($urandom_range(0, 1));
      pcsrc_d     = 1'($urandom_range(0, 1));
      memaccess_m = ($urandom_range(0, 2) == 0);
      dmem_ack    = ($urandom_range(0, 3) == 0);
      step();
    end
    clear_inputs();

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
